fetch_pc_unit: RTL and testbench

//  Instruction-fetch stage of the 5-stage MIPS core: holds the PC, drives the instruction-memory address,
//  and registers the fetched word into the IF/ID pipeline register.

---
 rtl/mips_pkg.sv | 28 ++
 rtl/fetch_pc_unit_if.sv | 34 +++
 rtl/fetch_pc_unit_ifid_reg.sv | 32 +++
 rtl/fetch_pc_unit.sv | 98 +++++++++
 tb/tb_fetch_pc_unit.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared constants, fetch FSM encoding and redirect target select
package mips_pkg;

    localparam logic [31:0] MIPS_NOP         = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

    // JR carries the freshest forwarded value, so it outranks J and branch.
    function automatic logic [31:0] select_target(
        input logic        jr,
        input logic        jump,
        input logic [31:0] jr_addr,
        input logic [31:0] j_addr,
        input logic [31:0] pc_branch
    );
        if (jr)
            return jr_addr;
        else if (jump)
            return j_addr;
        else
            return pc_branch;
    endfunction

endpackage

// File: rtl/fetch_pc_unit_if.sv
// rtl/fetch_pc_unit_if.sv - fetch-stage bus: ID redirects, imem port, IF/ID outputs, counters
interface fetch_pc_unit_if #(
    parameter int IMEM_AW = 10
);
    logic               stall;
    logic               branch;
    logic [31:0]        pc_branch;
    logic               jump;
    logic [31:0]        j_addr;
    logic               jr;
    logic [31:0]        jr_addr;
    logic               halt;
    logic               go;
    logic [31:0]        imem_data;
    logic [IMEM_AW-1:0] imem_addr;
    logic [31:0]        pc;
    logic [31:0]        ifid_ins;
    logic [31:0]        ifid_pc;
    logic               ifid_valid;
    logic               halted;
    logic [31:0]        cycle_cnt;
    logic [31:0]        redirect_cnt;

    modport master (
        input  stall, branch, pc_branch, jump, j_addr, jr, jr_addr, halt, go, imem_data,
        output imem_addr, pc, ifid_ins, ifid_pc, ifid_valid, halted, cycle_cnt, redirect_cnt
    );

    modport slave (
        output stall, branch, pc_branch, jump, j_addr, jr, jr_addr, halt, go, imem_data,
        input  imem_addr, pc, ifid_ins, ifid_pc, ifid_valid, halted, cycle_cnt, redirect_cnt
    );

endinterface

// File: rtl/fetch_pc_unit_ifid_reg.sv
// rtl/fetch_pc_unit_ifid_reg.sv - IF/ID pipeline register with hold and bubble-flush controls
module ifid_reg
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        flush,
    input  logic [31:0] ins_in,
    input  logic [31:0] pc_in,
    output logic [31:0] ins,
    output logic [31:0] pc,
    output logic        valid
);

    // A flush only kills the instruction; the pc field keeps its last value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ins   <= MIPS_NOP;
            pc    <= 32'h0;
            valid <= 1'b0;
        end else if (flush) begin
            ins   <= MIPS_NOP;
            valid <= 1'b0;
        end else if (en) begin
            ins   <= ins_in;
            pc    <= pc_in;
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// rtl/fetch_pc_unit.sv - instruction fetch: PC, next-PC mux, RUN/HALT FSM, perf counters
module fetch_pc_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          IMEM_AW  = 10
) (
    input  logic            clk,
    input  logic            rst,
    fetch_pc_unit_if.master bus
);

    fetch_state_t state_q;
    fetch_state_t state_d;
    logic [31:0]  pc_q;
    logic [31:0]  pc_d;
    logic [31:0]  cycle_q;
    logic [31:0]  redirect_q;
    logic         ifid_en;
    logic         ifid_flush;
    logic         cycle_inc;
    logic         redirect_inc;
    logic         redirect;
    logic [31:0]  target;

    assign redirect = !bus.stall && (bus.jr || bus.jump || bus.branch);
    assign target   = select_target(bus.jr, bus.jump, bus.jr_addr, bus.j_addr, bus.pc_branch);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RUN;
            pc_q       <= RESET_PC;
            cycle_q    <= 32'h0;
            redirect_q <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (cycle_inc)
                cycle_q <= cycle_q + 32'd1;
            if (redirect_inc)
                redirect_q <= redirect_q + 32'd1;
        end
    end

    // Stall outranks halt so a load-use bubble is never lost across a halt.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ifid_en      = 1'b0;
        ifid_flush   = 1'b0;
        cycle_inc    = 1'b0;
        redirect_inc = 1'b0;
        case (state_q)
            RUN: begin
                cycle_inc = 1'b1;
                if (bus.stall) begin
                    pc_d = pc_q;
                end else if (bus.halt) begin
                    state_d    = HALT;
                    ifid_flush = 1'b1;
                end else if (redirect) begin
                    pc_d         = target;
                    ifid_flush   = 1'b1;
                    redirect_inc = 1'b1;
                end else begin
                    pc_d    = pc_q + 32'd4;
                    ifid_en = 1'b1;
                end
            end
            HALT: begin
                if (bus.go && !bus.halt)
                    state_d = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    ifid_reg u_ifid (
        .clk    (clk),
        .rst    (rst),
        .en     (ifid_en),
        .flush  (ifid_flush),
        .ins_in (bus.imem_data),
        .pc_in  (pc_q),
        .ins    (bus.ifid_ins),
        .pc     (bus.ifid_pc),
        .valid  (bus.ifid_valid)
    );

    assign bus.imem_addr    = pc_q[IMEM_AW+1:2];
    assign bus.pc           = pc_q;
    assign bus.halted       = (state_q == HALT);
    assign bus.cycle_cnt    = cycle_q;
    assign bus.redirect_cnt = redirect_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb/tb_fetch_pc_unit.sv - directed vector table, async reset sequences and random run vs reference model
module tb_fetch_pc_unit;

    localparam int          AW    = 10;
    localparam logic [31:0] CONST = 32'h2008_0001;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    fetch_pc_unit_if #(.IMEM_AW(AW)) bus ();

    fetch_pc_unit #(.RESET_PC(32'h0), .IMEM_AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        stall, branch, jump, jr, halt, go;
        logic [31:0] pcb, ja, jra;
        logic [31:0] e_pc, e_ipc;
        logic        e_valid, e_halted;
        logic [31:0] e_red, e_cyc;
    } vec_t;

    vec_t tbl [18];

    logic [31:0] m_pc, m_ins, m_ipc, m_cyc, m_red;
    logic        m_valid, m_halted;
    logic        const_mode;
    logic [31:0] cur_word;

    function automatic vec_t mk(input logic s, b, j, r, h, g,
                                input logic [31:0] pcb, ja, jra, epc, eipc,
                                input logic ev, eh, input logic [31:0] ered, ecyc);
        vec_t v;
        v.stall = s; v.branch = b; v.jump = j; v.jr = r; v.halt = h; v.go = g;
        v.pcb = pcb; v.ja = ja; v.jra = jra; v.e_pc = epc; v.e_ipc = eipc;
        v.e_valid = ev; v.e_halted = eh; v.e_red = ered; v.e_cyc = ecyc;
        return v;
    endfunction

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_ins = 32'h0; m_ipc = 32'h0; m_valid = 1'b0;
        m_halted = 1'b0; m_cyc = 32'h0; m_red = 32'h0;
    endtask

    task automatic drive(input logic s, b, j, r, h, g, input logic [31:0] pcb, ja, jra);
        bus.stall = s; bus.branch = b; bus.jump = j; bus.jr = r; bus.halt = h; bus.go = g;
        bus.pc_branch = pcb; bus.j_addr = ja; bus.jr_addr = jra;
    endtask

    // One clock: present inputs and the word at the model's fetch address, then advance the model.
    task automatic cycle(input logic s, b, j, r, h, g, input logic [31:0] pcb, ja, jra);
        drive(s, b, j, r, h, g, pcb, ja, jra);
        cur_word = const_mode ? CONST : word_of(m_pc);
        bus.imem_data = cur_word;
        @(posedge clk);
        if (!m_halted) begin
            m_cyc = m_cyc + 1;
            if (s) begin
                m_cyc = m_cyc;
            end else if (h) begin
                m_halted = 1'b1; m_valid = 1'b0; m_ins = 32'h0;
            end else if (r || j || b) begin
                m_pc = r ? jra : (j ? ja : pcb);
                m_valid = 1'b0; m_ins = 32'h0; m_red = m_red + 1;
            end else begin
                m_ipc = m_pc; m_ins = cur_word; m_valid = 1'b1; m_pc = m_pc + 32'd4;
            end
        end else if (g && !h) begin
            m_halted = 1'b0;
        end
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, " pc"},        bus.pc,                       m_pc);
        chk({tag, " imem_addr"}, 32'(bus.imem_addr),           32'(m_pc[AW+1:2]));
        chk({tag, " ifid_ins"},  bus.ifid_ins,                 m_ins);
        chk({tag, " ifid_pc"},   bus.ifid_pc,                  m_ipc);
        chk({tag, " ifid_valid"},32'(bus.ifid_valid),          32'(m_valid));
        chk({tag, " halted"},    32'(bus.halted),              32'(m_halted));
        chk({tag, " cycle_cnt"}, bus.cycle_cnt,                m_cyc);
        chk({tag, " redir_cnt"}, bus.redirect_cnt,             m_red);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, " pc"},         bus.pc,                 32'h0);
        chk({tag, " ifid_ins"},   bus.ifid_ins,           32'h0);
        chk({tag, " ifid_pc"},    bus.ifid_pc,            32'h0);
        chk({tag, " ifid_valid"}, 32'(bus.ifid_valid),    32'h0);
        chk({tag, " halted"},     32'(bus.halted),        32'h0);
        chk({tag, " cycle_cnt"},  bus.cycle_cnt,          32'h0);
        chk({tag, " redir_cnt"},  bus.redirect_cnt,       32'h0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        const_mode = 1'b1;
        cur_word = CONST;
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
        bus.imem_data = CONST;
        model_reset();
        #12;
        check_reset("reset");
        rst = 1'b0;

        // Directed walk: sequential fetch, branch, triple redirect, stalled branch, jump, halt/resume.
        tbl[0]  = mk(0,0,0,0,0,0, 32'h0,   32'h0,   32'h0,   32'h4,   32'h0,   1,0, 0, 1);
        tbl[1]  = mk(0,0,0,0,0,0, 32'h0,   32'h0,   32'h0,   32'h8,   32'h4,   1,0, 0, 2);
        tbl[2]  = mk(0,1,0,0,0,0, 32'h40,  32'h0,   32'h0,   32'h40,  32'h4,   0,0, 1, 3);
        tbl[3]  = mk(0,0,0,0,0,0, 32'h0,   32'h0,   32'h0,   32'h44,  32'h40,  1,0, 1, 4);
        tbl[4]  = mk(0,1,1,1,0,0, 32'h300, 32'h200, 32'h100, 32'h100, 32'h40,  0,0, 2, 5);
        tbl[5]  = mk(0,0,0,0,0,0, 32'h0,   32'h0,   32'h0,   32'h104, 32'h100, 1,0, 2, 6);
        tbl[6]  = mk(1,1,0,0,0,0, 32'h500, 32'h0,   32'h0,   32'h104, 32'h100, 1,0, 2, 7);
        tbl[7]  = mk(1,1,0,0,0,0, 32'h500, 32'h0,   32'h0,   32'h104, 32'h100, 1,0, 2, 8);
        tbl[8]  = mk(0,1,0,0,0,0, 32'h500, 32'h0,   32'h0,   32'h500, 32'h100, 0,0, 3, 9);
        tbl[9]  = mk(0,0,1,0,0,0, 32'h0,   32'h14,  32'h0,   32'h14,  32'h100, 0,0, 4, 10);
        tbl[10] = mk(0,0,0,0,0,0, 32'h0,   32'h0,   32'h0,   32'h18,  32'h14,  1,0, 4, 11);
        tbl[11] = mk(0,0,0,0,0,0, 32'h0,   32'h0,   32'h0,   32'h1c,  32'h18,  1,0, 4, 12);
        tbl[12] = mk(0,0,0,0,0,0, 32'h0,   32'h0,   32'h0,   32'h20,  32'h1c,  1,0, 4, 13);
        tbl[13] = mk(0,0,0,0,1,0, 32'h0,   32'h0,   32'h0,   32'h20,  32'h1c,  0,1, 4, 14);
        tbl[14] = mk(1,1,0,0,0,0, 32'h600, 32'h0,   32'h0,   32'h20,  32'h1c,  0,1, 4, 14);
        tbl[15] = mk(0,0,0,0,1,1, 32'h0,   32'h0,   32'h0,   32'h20,  32'h1c,  0,1, 4, 14);
        tbl[16] = mk(0,0,0,0,0,1, 32'h0,   32'h0,   32'h0,   32'h20,  32'h1c,  0,0, 4, 14);
        tbl[17] = mk(0,0,0,0,0,0, 32'h0,   32'h0,   32'h0,   32'h24,  32'h20,  1,0, 4, 15);

        for (int i = 0; i < 18; i++) begin
            cycle(tbl[i].stall, tbl[i].branch, tbl[i].jump, tbl[i].jr, tbl[i].halt, tbl[i].go,
                  tbl[i].pcb, tbl[i].ja, tbl[i].jra);
            chk($sformatf("row%0d pc", i),         bus.pc,                tbl[i].e_pc);
            chk($sformatf("row%0d ifid_pc", i),    bus.ifid_pc,           tbl[i].e_ipc);
            chk($sformatf("row%0d ifid_valid", i), 32'(bus.ifid_valid),   32'(tbl[i].e_valid));
            chk($sformatf("row%0d ifid_ins", i),   bus.ifid_ins,          tbl[i].e_valid ? CONST : 32'h0);
            chk($sformatf("row%0d halted", i),     32'(bus.halted),       32'(tbl[i].e_halted));
            chk($sformatf("row%0d redir_cnt", i),  bus.redirect_cnt,      tbl[i].e_red);
            chk($sformatf("row%0d cycle_cnt", i),  bus.cycle_cnt,         tbl[i].e_cyc);
        end

        // Asynchronous reset while a branch is being presented, between clock edges.
        drive(0, 1, 0, 0, 0, 0, 32'h80, 32'h0, 32'h0);
        #2 rst = 1'b1;
        #1 check_reset("rst_redirect");
        drive(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
        #2 rst = 1'b0;
        model_reset();

        // Asynchronous reset while halted.
        cycle(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
        cycle(0, 0, 0, 0, 1, 0, 32'h0, 32'h0, 32'h0);
        chk("pre_rst halted", 32'(bus.halted), 32'h1);
        #2 rst = 1'b1;
        #1 check_reset("rst_halt");
        drive(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
        #2 rst = 1'b0;
        model_reset();

        // Randomized traffic against the reference model.
        const_mode = 1'b0;
        for (int n = 0; n < 600; n++) begin
            logic [31:0] t0, t1, t2;
            t0 = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : $urandom;
            t1 = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : $urandom;
            t2 = $urandom;
            cycle($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 19) == 0, $urandom_range(0, 2) == 0,
                  t2, t1, t0);
            check_model($sformatf("rand%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
